// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 icode, register id and default width constants
package y86_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 15;
  localparam int REG_ID_W_DEF = 4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - register file, two write ports (M wins), two bypassed reads
// Optional committed-state debug read port under DECODE_WB_DBG_PORT_EN.
module y86_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int REG_ID_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REG_ID_W-1:0] w_dstE_i,
  input  logic [DATA_W-1:0]   w_valE_i,
  input  logic [REG_ID_W-1:0] w_dstM_i,
  input  logic [DATA_W-1:0]   w_valM_i,
  input  logic [REG_ID_W-1:0] srcA_i,
  input  logic [REG_ID_W-1:0] srcB_i,
`ifdef DECODE_WB_DBG_PORT_EN
  input  logic [REG_ID_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0]   dbg_rdata_o,
`endif
  output logic [DATA_W-1:0]   valA_o,
  output logic [DATA_W-1:0]   valB_o
);

  localparam logic [REG_ID_W-1:0] RNONE_ID    = {REG_ID_W{1'b1}};
  localparam logic [REG_ID_W:0]   NUM_REGS_ID = (REG_ID_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] commit_a;
  logic [DATA_W-1:0] commit_b;
  logic              a_ok;
  logic              b_ok;

  // RNONE and out-of-range ids never match a loop index, so they write nothing.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (w_dstM_i == REG_ID_W'(i)) begin
        regs_d[i] = w_valM_i;
      end else if (w_dstE_i == REG_ID_W'(i)) begin
        regs_d[i] = w_valE_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    commit_a = '0;
    commit_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (srcA_i == REG_ID_W'(i)) commit_a = regs_q[i];
      if (srcB_i == REG_ID_W'(i)) commit_b = regs_q[i];
    end
  end

  assign a_ok = (srcA_i != RNONE_ID) && ({1'b0, srcA_i} < NUM_REGS_ID);
  assign b_ok = (srcB_i != RNONE_ID) && ({1'b0, srcB_i} < NUM_REGS_ID);

  // Bypass the value being written this cycle; the M port has priority.
  assign valA_o = !a_ok                ? '0 :
                  (srcA_i == w_dstM_i) ? w_valM_i :
                  (srcA_i == w_dstE_i) ? w_valE_i : commit_a;
  assign valB_o = !b_ok                ? '0 :
                  (srcB_i == w_dstM_i) ? w_valM_i :
                  (srcB_i == w_dstE_i) ? w_valE_i : commit_b;

`ifdef DECODE_WB_DBG_PORT_EN
  always_comb begin
    dbg_rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dbg_raddr_i == REG_ID_W'(i)) dbg_rdata_o = regs_q[i];
    end
  end
`endif

endmodule

// File: rtl/decode_wb_pipe.sv
// rtl/decode_wb_pipe.sv - W pipeline register with cmov gating plus bypassed register file
// Optional debug read port under DECODE_WB_DBG_PORT_EN.
module decode_wb_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_w_i,
  input  logic                bubble_w_i,
  input  logic [3:0]          m_icode_i,
  input  logic                m_cnd_i,
  input  logic [REG_ID_W-1:0] m_dstE_i,
  input  logic [REG_ID_W-1:0] m_dstM_i,
  input  logic [DATA_W-1:0]   m_valE_i,
  input  logic [DATA_W-1:0]   m_valM_i,
  input  logic [REG_ID_W-1:0] d_srcA_i,
  input  logic [REG_ID_W-1:0] d_srcB_i,
`ifdef DECODE_WB_DBG_PORT_EN
  input  logic [REG_ID_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0]   dbg_rdata_o,
`endif
  output logic [DATA_W-1:0]   d_valA_o,
  output logic [DATA_W-1:0]   d_valB_o,
  output logic [3:0]          w_icode_o,
  output logic [REG_ID_W-1:0] w_dstE_o,
  output logic [DATA_W-1:0]   w_valE_o,
  output logic [REG_ID_W-1:0] w_dstM_o,
  output logic [DATA_W-1:0]   w_valM_o
);

  localparam logic [REG_ID_W-1:0] RNONE_ID = {REG_ID_W{1'b1}};

  logic [3:0]          w_icode_q, w_icode_d;
  logic [REG_ID_W-1:0] w_dstE_q,  w_dstE_d;
  logic [DATA_W-1:0]   w_valE_q,  w_valE_d;
  logic [REG_ID_W-1:0] w_dstM_q,  w_dstM_d;
  logic [DATA_W-1:0]   w_valM_q,  w_valM_d;

  // Stall beats bubble; a not-taken cmov loses its E destination.
  always_comb begin
    w_icode_d = w_icode_q;
    w_dstE_d  = w_dstE_q;
    w_valE_d  = w_valE_q;
    w_dstM_d  = w_dstM_q;
    w_valM_d  = w_valM_q;
    if (!stall_w_i) begin
      if (bubble_w_i) begin
        w_icode_d = INOP;
        w_dstE_d  = RNONE_ID;
        w_valE_d  = '0;
        w_dstM_d  = RNONE_ID;
        w_valM_d  = '0;
      end else begin
        w_icode_d = m_icode_i;
        w_dstE_d  = (m_icode_i == IRRMOVQ && !m_cnd_i) ? RNONE_ID : m_dstE_i;
        w_valE_d  = m_valE_i;
        w_dstM_d  = m_dstM_i;
        w_valM_d  = m_valM_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_icode_q <= INOP;
      w_dstE_q  <= RNONE_ID;
      w_valE_q  <= '0;
      w_dstM_q  <= RNONE_ID;
      w_valM_q  <= '0;
    end else begin
      w_icode_q <= w_icode_d;
      w_dstE_q  <= w_dstE_d;
      w_valE_q  <= w_valE_d;
      w_dstM_q  <= w_dstM_d;
      w_valM_q  <= w_valM_d;
    end
  end

  assign w_icode_o = w_icode_q;
  assign w_dstE_o  = w_dstE_q;
  assign w_valE_o  = w_valE_q;
  assign w_dstM_o  = w_dstM_q;
  assign w_valM_o  = w_valM_q;

  y86_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_ID_W (REG_ID_W)
  ) u_regfile (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .w_dstE_i    (w_dstE_q),
    .w_valE_i    (w_valE_q),
    .w_dstM_i    (w_dstM_q),
    .w_valM_i    (w_valM_q),
    .srcA_i      (d_srcA_i),
    .srcB_i      (d_srcB_i),
`ifdef DECODE_WB_DBG_PORT_EN
    .dbg_raddr_i (dbg_raddr_i),
    .dbg_rdata_o (dbg_rdata_o),
`endif
    .valA_o      (d_valA_o),
    .valB_o      (d_valB_o)
  );

endmodule

// File: tb/tb_decode_wb_pipe.sv
// tb/tb_decode_wb_pipe.sv - scoreboard bench for decode_wb_pipe
module tb_decode_wb_pipe;
  import y86_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_w_i, bubble_w_i;
  logic [3:0]  m_icode_i;
  logic        m_cnd_i;
  logic [3:0]  m_dstE_i, m_dstM_i;
  logic [63:0] m_valE_i, m_valM_i;
  logic [3:0]  d_srcA_i, d_srcB_i;
  logic [63:0] d_valA_o, d_valB_o;
  logic [3:0]  w_icode_o, w_dstE_o, w_dstM_o;
  logic [63:0] w_valE_o, w_valM_o;
`ifdef DECODE_WB_DBG_PORT_EN
  logic [3:0]  dbg_raddr_i;
  logic [63:0] dbg_rdata_o;
`endif

  always #5 clk_i = ~clk_i;

  decode_wb_pipe dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .stall_w_i  (stall_w_i),
    .bubble_w_i (bubble_w_i),
    .m_icode_i  (m_icode_i),
    .m_cnd_i    (m_cnd_i),
    .m_dstE_i   (m_dstE_i),
    .m_dstM_i   (m_dstM_i),
    .m_valE_i   (m_valE_i),
    .m_valM_i   (m_valM_i),
    .d_srcA_i   (d_srcA_i),
    .d_srcB_i   (d_srcB_i),
`ifdef DECODE_WB_DBG_PORT_EN
    .dbg_raddr_i(dbg_raddr_i),
    .dbg_rdata_o(dbg_rdata_o),
`endif
    .d_valA_o   (d_valA_o),
    .d_valB_o   (d_valB_o),
    .w_icode_o  (w_icode_o),
    .w_dstE_o   (w_dstE_o),
    .w_valE_o   (w_valE_o),
    .w_dstM_o   (w_dstM_o),
    .w_valM_o   (w_valM_o)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
  } wreg_t;

  localparam wreg_t BUBBLE = '{INOP, 4'hF, 64'd0, 4'hF, 64'd0};

  int          checks = 0;
  int          failures = 0;
  wreg_t       mw;
  logic [63:0] mr [15];
  wreg_t       exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [3:0] s);
    if (s >= 4'd15) return 64'd0;
    if (s == mw.dstM) return mw.valM;
    if (s == mw.dstE) return mw.valE;
    return mr[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mr[i] = 64'd0;
    mw = BUBBLE;
  endtask

  task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] de,
                      input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                      input logic st, input logic bu);
    wreg_t nxt;
    wreg_t e;
    m_icode_i = ic; m_cnd_i = c; m_dstE_i = de; m_valE_i = ve;
    m_dstM_i = dm; m_valM_i = vm; stall_w_i = st; bubble_w_i = bu;
    if (st) nxt = mw;
    else if (bu) nxt = BUBBLE;
    else nxt = '{ic, (ic == IRRMOVQ && !c) ? 4'hF : de, ve, dm, vm};
    exp_q.push_back(nxt);
    @(posedge clk_i);
    for (int i = 0; i < 15; i++) begin
      if (mw.dstM == 4'(i)) mr[i] = mw.valM;
      else if (mw.dstE == 4'(i)) mr[i] = mw.valE;
    end
    mw = nxt;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("w_icode", 64'(w_icode_o), 64'(e.icode));
      check("w_dstE",  64'(w_dstE_o),  64'(e.dstE));
      check("w_valE",  w_valE_o,       e.valE);
      check("w_dstM",  64'(w_dstM_o),  64'(e.dstM));
      check("w_valM",  w_valM_o,       e.valM);
    end
  endtask

  task automatic bub();
    step(IOPQ, 1'b1, 4'd3, 64'hDEAD, 4'd3, 64'hBEEF, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    d_srcA_i = a; d_srcB_i = b;
    #1;
    check("d_valA", d_valA_o, mread(a));
    check("d_valB", d_valB_o, mread(b));
  endtask

  initial begin
    rst_i = 1'b1;
    stall_w_i = 1'b0; bubble_w_i = 1'b0;
    m_icode_i = INOP; m_cnd_i = 1'b0; m_dstE_i = RNONE; m_dstM_i = RNONE;
    m_valE_i = '0; m_valM_i = '0; d_srcA_i = RNONE; d_srcB_i = RNONE;
`ifdef DECODE_WB_DBG_PORT_EN
    dbg_raddr_i = 4'd4;
`endif
    model_reset();
    #2;
    check("rst_icode", 64'(w_icode_o), 64'(INOP));
    check("rst_dstE",  64'(w_dstE_o),  64'hF);
    check("rst_dstM",  64'(w_dstM_o),  64'hF);
    check("rst_valE",  w_valE_o, 64'd0);
    rd(4'd0, 4'd14);
    #10 rst_i = 1'b0;

    step(IOPQ, 1'b1, 4'd1, 64'd3, RNONE, 64'd0, 1'b0, 1'b0);
    rd(4'd1, 4'd0);
    check("bypass_opq", d_valA_o, 64'd3);
    bub();
    rd(4'd1, 4'd2);
    check("commit_r1", d_valA_o, 64'd3);

    step(IPOPQ, 1'b1, RSP, 64'd7, RSP, 64'd6, 1'b0, 1'b0);
    rd(RSP, 4'd1);
    check("popq_bypass", d_valA_o, 64'd6);
    bub();
    rd(RSP, 4'd1);
    check("popq_commit", d_valA_o, 64'd6);

    step(IRRMOVQ, 1'b0, 4'd2, 64'd9, RNONE, 64'd0, 1'b0, 1'b0);
    check("cmov_nt_dstE", 64'(w_dstE_o), 64'hF);
    bub();
    rd(4'd2, 4'd1);
    check("cmov_nt_r2", d_valA_o, 64'd0);
    step(IRRMOVQ, 1'b1, 4'd2, 64'd9, RNONE, 64'd0, 1'b0, 1'b0);
    bub();
    rd(4'd2, 4'd1);
    check("cmov_t_r2", d_valA_o, 64'd9);

    step(IOPQ, 1'b1, 4'd5, 64'hA, RNONE, 64'd0, 1'b0, 1'b0);
    step(IIRMOVQ, 1'b1, 4'd6, 64'h99, 4'd7, 64'h77, 1'b1, 1'b1);
    rd(4'd5, 4'd6);
    step(IIRMOVQ, 1'b1, 4'd6, 64'h99, 4'd7, 64'h77, 1'b0, 1'b1);
    check("bubble_icode", 64'(w_icode_o), 64'(INOP));
    rd(4'd5, 4'd6);
    check("stall_r5", d_valA_o, 64'hA);
    check("stall_r6", d_valB_o, 64'd0);

    step(IOPQ, 1'b1, RNONE, 64'h123, RNONE, 64'h456, 1'b0, 1'b0);
    rd(RNONE, RNONE);
    step(IOPQ, 1'b1, RSP, 64'h55, RNONE, 64'd0, 1'b0, 1'b0);
    rd(RSP, RNONE);
`ifdef DECODE_WB_DBG_PORT_EN
    dbg_raddr_i = RSP; #1;
    check("dbg_r4_committed", dbg_rdata_o, mr[4]);
    dbg_raddr_i = RNONE; #1;
    check("dbg_rnone", dbg_rdata_o, 64'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [3:0] ic;
      ic = 4'($urandom_range(0, 11));
      step(ic, 1'($urandom), 4'($urandom), {$urandom, $urandom}, 4'($urandom),
           {$urandom, $urandom}, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      rd(4'($urandom), 4'($urandom));
`ifdef DECODE_WB_DBG_PORT_EN
      dbg_raddr_i = 4'($urandom); #1;
      check("dbg_rand", dbg_rdata_o, (dbg_raddr_i < 4'd15) ? mr[dbg_raddr_i] : 64'd0);
`endif
    end

    step(IOPQ, 1'b1, 4'd8, 64'h88, 4'd9, 64'h99, 1'b0, 1'b0);
    rst_i = 1'b1;
    model_reset();
    #1;
    check("midrst_icode", 64'(w_icode_o), 64'(INOP));
    check("midrst_dstE",  64'(w_dstE_o),  64'hF);
    check("midrst_dstM",  64'(w_dstM_o),  64'hF);
    for (int a = 0; a < 15; a++) rd(4'(a), 4'(14 - a));
    @(negedge clk_i);
    rst_i = 1'b0;
    step(IOPQ, 1'b1, 4'd1, 64'h11, RNONE, 64'd0, 1'b0, 1'b0);
    rd(4'd1, 4'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
